// File: rtl/encounter_spawner_if.sv
// Sprite ROM port between encounter_spawner and an external synchronous ROM.
//   rom_addr : ROM word address, driven by the spawner
//   rom_data : ROM word, valid one clock after rom_addr; [3:0]=R [7:4]=G [11:8]=B
interface encounter_spawner_if #(
  parameter int ADDR_W = 13
) ();
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/encounter_spawner.sv
// Multi-slot obstacle spawner. Spawns obstacles at the right edge on a key
// press, scrolls them left on every frame tick, animates them through a
// shared sprite frame, and draws them from an external sprite ROM.
//
// Ports:
//   clock, reset       pixel clock, synchronous active-low reset
//   display_col/row    current scan position from the VGA timing generator
//   visible            active video region
//   spawn_key          spawn request, rising edge counts
//   hit                freeze motion, animation and spawning (drawing continues)
//   rom                sprite ROM port (master side)
//   enc_red/green/blue pixel colour, 3 clocks after the scan position
//   enc_visible        obstacle pixel present
//   active_mask        bit i = slot i occupied
//   spawn_pending      latched spawn request not yet serviced
module encounter_spawner #(
  parameter int          N_SLOTS     = 4,
  parameter int          SPAWN_X     = 1500,
  parameter int          BASE_Y      = 690,
  parameter int          SPEED       = 6,
  parameter int          SPRITE_W    = 128,
  parameter int          SPRITE_H    = 128,
  parameter int          SCALE_SHIFT = 2,
  parameter int          N_FRAMES    = 5,
  parameter int          ANIM_TICKS  = 20000000,
  parameter int          MIN_GAP     = 256,
  parameter logic [11:0] TRANSPARENT = 12'hC0F,
  parameter int          ADDR_W      = 13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        display_col,
  input  logic [10:0]        display_row,
  input  logic               visible,
  input  logic               spawn_key,
  input  logic               hit,
  encounter_spawner_if.master rom,
  output logic [3:0]         enc_red,
  output logic [3:0]         enc_green,
  output logic [3:0]         enc_blue,
  output logic               enc_visible,
  output logic [N_SLOTS-1:0] active_mask,
  output logic               spawn_pending
);

  localparam int TEX_W   = SPRITE_W >> SCALE_SHIFT;
  localparam int TEX_H   = SPRITE_H >> SCALE_SHIFT;
  localparam int TX_BITS = (TEX_W > 1) ? $clog2(TEX_W) : 1;
  localparam int TY_BITS = (TEX_H > 1) ? $clog2(TEX_H) : 1;
  localparam int FW      = TEX_W * TEX_H;
  localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int ANIM_W  = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  localparam logic [11:0]        GAP_LIMIT  = 12'(SPAWN_X - MIN_GAP);
  localparam logic [11:0]        SPAWN_POS  = 12'(SPAWN_X);
  localparam logic [11:0]        STEP       = 12'(SPEED);
  localparam logic [11:0]        ROW_TOP    = 12'(BASE_Y);
  localparam logic [11:0]        ROW_END    = 12'(BASE_Y + SPRITE_H);
  localparam logic [12:0]        WIDTH13    = 13'(SPRITE_W);
  localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_FRAMES - 1);

  // Slot state
  logic [11:0]        r_x [N_SLOTS];
  logic [N_SLOTS-1:0] r_active;
  logic [SLOT_W-1:0]  r_newest;

  // Spawn request and animation
  logic               r_key_d;
  logic               r_pending;
  logic [ANIM_W-1:0]  r_anim_cnt;
  logic [FRAME_W-1:0] r_frame;

  // Pixel pipeline
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_cov1, r_cov2;
  logic               r_vis1, r_vis2;
  logic [3:0]         r_red, r_green, r_blue;
  logic               r_enc_vis;

  logic               w_tick;
  logic               w_key_rise;
  logic               w_free_found;
  logic [SLOT_W-1:0]  w_free_idx;
  logic               w_gap_ok;
  logic               w_do_spawn;
  logic               w_row_in;
  logic               w_cov;
  logic [11:0]        w_sel_x;
  logic [11:0]        w_ix;
  logic [10:0]        w_iy;
  logic [TX_BITS+TY_BITS-1:0] w_tex;
  logic [ADDR_W-1:0]  w_frame_base;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_unused;

  assign w_tick     = (display_col == 12'd0) && (display_row == 11'd0);
  assign w_key_rise = spawn_key && !r_key_d;

  // Spawn decision looks only at slot state from before the tick, so a slot
  // freed on this tick is not reused until the next one.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
    w_gap_ok   = !r_active[r_newest] || (r_x[r_newest] <= GAP_LIMIT);
    w_do_spawn = w_tick && !hit && r_pending && w_free_found && w_gap_ok;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_x[i] <= '0;
      end
      r_active <= '0;
      r_newest <= '0;
    end else if (w_tick && !hit) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_do_spawn && (w_free_idx == SLOT_W'(i))) begin
          r_active[i] <= 1'b1;
          r_x[i]      <= SPAWN_POS;
        end else if (r_active[i]) begin
          if (r_x[i] > STEP) begin
            r_x[i] <= r_x[i] - STEP;
          end else begin
            r_active[i] <= 1'b0;
            r_x[i]      <= '0;
          end
        end
      end
      if (w_do_spawn) begin
        r_newest <= w_free_idx;
      end
    end
  end

  // Edge detection keeps running while frozen; only servicing stops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_key_d   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_key_d <= spawn_key;
      if (r_pending) begin
        if (w_do_spawn) begin
          r_pending <= 1'b0;
        end
      end else if (w_key_rise) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_anim_cnt <= '0;
      r_frame    <= '0;
    end else if (!hit) begin
      if (r_anim_cnt == ANIM_LAST) begin
        r_anim_cnt <= '0;
        r_frame    <= (r_frame == FRAME_LAST) ? '0 : r_frame + 1'b1;
      end else begin
        r_anim_cnt <= r_anim_cnt + 1'b1;
      end
    end
  end

  // Cover test; iterating downwards lets the lowest covering index win.
  assign w_row_in = ({1'b0, display_row} >= ROW_TOP) && ({1'b0, display_row} < ROW_END);

  always_comb begin
    w_cov   = 1'b0;
    w_sel_x = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (r_active[i] && w_row_in && (display_col >= r_x[i]) &&
          ({1'b0, display_col} < ({1'b0, r_x[i]} + WIDTH13))) begin
        w_cov   = 1'b1;
        w_sel_x = r_x[i];
      end
    end
  end

  assign w_ix         = display_col - w_sel_x;
  assign w_iy         = display_row - 11'(BASE_Y);
  // Column texel in the high field, row texel in the low field.
  assign w_tex        = {w_ix[SCALE_SHIFT +: TX_BITS], w_iy[SCALE_SHIFT +: TY_BITS]};
  assign w_frame_base = ADDR_W'(int'(r_frame) * FW);
  assign w_addr       = w_cov ? (w_frame_base + ADDR_W'(w_tex)) : '0;
  assign w_unused     = ^{w_ix, w_iy};

  // Stage 1: address out, flags start their two-stage delay to meet rom_data.
  // Stage 2: ROM returns data. Stage 3: colour registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rom_addr <= '0;
      r_cov1     <= 1'b0;
      r_vis1     <= 1'b0;
      r_cov2     <= 1'b0;
      r_vis2     <= 1'b0;
      r_red      <= 4'hF;
      r_green    <= 4'hF;
      r_blue     <= 4'hF;
      r_enc_vis  <= 1'b0;
    end else begin
      r_rom_addr <= w_addr;
      r_cov1     <= w_cov;
      r_vis1     <= visible;
      r_cov2     <= r_cov1;
      r_vis2     <= r_vis1;
      if (r_cov2 && r_vis2 && (rom.rom_data != TRANSPARENT)) begin
        r_red     <= rom.rom_data[3:0];
        r_green   <= rom.rom_data[7:4];
        r_blue    <= rom.rom_data[11:8];
        r_enc_vis <= 1'b1;
      end else begin
        r_red     <= 4'hF;
        r_green   <= 4'hF;
        r_blue    <= 4'hF;
        r_enc_vis <= 1'b0;
      end
    end
  end

  assign rom.rom_addr  = r_rom_addr;
  assign enc_red       = r_red;
  assign enc_green     = r_green;
  assign enc_blue      = r_blue;
  assign enc_visible   = r_enc_vis;
  assign active_mask   = r_active;
  assign spawn_pending = r_pending;

endmodule

// File: tb/tb_encounter_spawner.sv
// Directed bench for encounter_spawner: reset values, spawn/scroll/free,
// gap rule, full slots, freeze, and the pixel path against a ROM that
// returns its address as data (texel 0 of every frame is transparent).
module tb_encounter_spawner;
  localparam int ANIM = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        visible;
  logic        spawn_key;
  logic        hit;
  logic [3:0]  enc_red, enc_green, enc_blue;
  logic        enc_visible;
  logic [3:0]  active_mask;
  logic        spawn_pending;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  encounter_spawner_if #(.ADDR_W(13)) rom_if ();

  encounter_spawner #(.ANIM_TICKS(ANIM)) dut (
    .clock        (clock),
    .reset        (reset),
    .display_col  (display_col),
    .display_row  (display_row),
    .visible      (visible),
    .spawn_key    (spawn_key),
    .hit          (hit),
    .rom          (rom_if),
    .enc_red      (enc_red),
    .enc_green    (enc_green),
    .enc_blue     (enc_blue),
    .enc_visible  (enc_visible),
    .active_mask  (active_mask),
    .spawn_pending(spawn_pending)
  );

  // Sprite ROM model
  always @(posedge clock)
    rom_if.rom_data <= (rom_if.rom_addr[9:0] == 10'd0) ? 12'hC0F : rom_if.rom_addr[11:0];

  // Animation frame model: ANIM clocks per step, frozen by hit
  int m_cnt, m_frame;
  always @(posedge clock) begin
    if (!reset) begin
      m_cnt   <= 0;
      m_frame <= 0;
    end else if (!hit) begin
      if (m_cnt == ANIM - 1) begin
        m_cnt   <= 0;
        m_frame <= (m_frame == 4) ? 0 : m_frame + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [11:0] col;
    logic [10:0] row;
    logic        vis;
    logic [12:0] addr;
    logic        ev;
    logic [11:0] bgr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle();
    display_col = 12'd5;
    display_row = 11'd5;
  endtask

  task automatic tick(input logic h);
    @(negedge clock);
    display_col = 12'd0;
    display_row = 11'd0;
    hit = h;
    @(negedge clock);
    idle();
  endtask

  task automatic press();
    @(negedge clock);
    spawn_key = 1'b1;
    @(negedge clock);
    spawn_key = 1'b0;
  endtask

  // Checks a slot sits at exactly column x for the given frame: the texel at
  // (x, BASE_Y+4) addresses frame*1024+1 and is drawn, column x-1 is empty.
  task automatic lookup_x(input string name, input int x, input int frame);
    logic [31:0] exp;
    exp = frame * 1024 + 1;
    hit = 1'b1;
    visible = 1'b1;
    display_col = 12'(x);
    display_row = 11'd694;
    @(negedge clock);
    chk({name, "_addr"}, 32'(dut.rom.rom_addr), exp);
    display_col = 12'(x - 1);
    @(negedge clock);
    chk({name, "_left"}, 32'(dut.rom.rom_addr), 0);
    idle();
    @(negedge clock);
    chk({name, "_vis"}, 32'(enc_visible), 1);
    chk({name, "_rgb"}, 32'({enc_blue, enc_green, enc_red}), 32'(exp[11:0]));
  endtask

  task automatic ticks_until_change(input logic [3:0] from, input int max,
                                    output int n, output logic pend_before);
    n = 0;
    pend_before = 1'b0;
    while (n < max) begin
      pend_before = spawn_pending;
      tick(1'b0);
      n++;
      if (active_mask != from) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, f0;
    logic pb;

    // col 1502 -> texel 0, row 694 -> texel 1: 2*1024 + 1
    vecs[0] = '{12'd1502, 11'd694, 1'b1, 13'd2049, 1'b1, 12'h801};
    vecs[1] = '{12'd1500, 11'd690, 1'b1, 13'd2048, 1'b0, 12'hFFF};
    vecs[2] = '{12'd1509, 11'd700, 1'b1, 13'd2114, 1'b1, 12'h842};
    vecs[3] = '{12'd1627, 11'd817, 1'b1, 13'd3071, 1'b1, 12'hBFF};
    vecs[4] = '{12'd1628, 11'd700, 1'b1, 13'd0,    1'b0, 12'hFFF};
    vecs[5] = '{12'd1499, 11'd700, 1'b1, 13'd0,    1'b0, 12'hFFF};
    vecs[6] = '{12'd1509, 11'd689, 1'b1, 13'd0,    1'b0, 12'hFFF};
    vecs[7] = '{12'd1509, 11'd818, 1'b1, 13'd0,    1'b0, 12'hFFF};
    vecs[8] = '{12'd1509, 11'd700, 1'b0, 13'd2114, 1'b0, 12'hFFF};

    reset = 1'b0;
    visible = 1'b1;
    spawn_key = 1'b0;
    hit = 1'b0;
    idle();
    repeat (3) @(negedge clock);
    chk("rst_mask", 32'(active_mask), 0);
    chk("rst_pending", 32'(spawn_pending), 0);
    chk("rst_addr", 32'(dut.rom.rom_addr), 0);
    chk("rst_vis", 32'(enc_visible), 0);
    chk("rst_rgb", 32'({enc_blue, enc_green, enc_red}), 32'hFFF);
    reset = 1'b1;

    // Single spawn
    press();
    chk("press_pending", 32'(spawn_pending), 1);
    tick(1'b0);
    chk("spawn_mask", 32'(active_mask), 1);
    chk("spawn_pending_clr", 32'(spawn_pending), 0);
    lookup_x("x_spawn", 1500, m_frame);

    // Run the animation to frame 2, then freeze it for the pixel table
    hit = 1'b0;
    for (k = 0; k < 2000; k++) begin
      if (m_frame == 2) break;
      @(negedge clock);
    end
    hit = 1'b1;
    chk("frame_reached", 32'(k < 2000), 1);

    // Exact latency: covered pixel presented for one clock
    idle();
    repeat (2) @(negedge clock);
    display_col = 12'd1502;
    display_row = 11'd694;
    @(negedge clock);
    chk("lat_e1", 32'(enc_visible), 0);
    idle();
    @(negedge clock);
    chk("lat_e2", 32'(enc_visible), 0);
    @(negedge clock);
    chk("lat_e3", 32'(enc_visible), 1);
    @(negedge clock);
    chk("lat_e4", 32'(enc_visible), 0);

    for (int i = 0; i < 9; i++) begin
      display_col = vecs[i].col;
      display_row = vecs[i].row;
      visible     = vecs[i].vis;
      @(negedge clock);
      chk($sformatf("vec%0d_addr", i), 32'(dut.rom.rom_addr), 32'(vecs[i].addr));
      idle();
      visible = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk($sformatf("vec%0d_vis", i), 32'(enc_visible), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_rgb", i), 32'({enc_blue, enc_green, enc_red}), 32'(vecs[i].bgr));
    end

    // One further tick moves by SPEED
    tick(1'b0);
    lookup_x("x_one_tick", 1494, m_frame);

    // Freeze: a press still latches, but nothing moves or is serviced
    f0 = m_frame;
    press();
    chk("frz_press_pending", 32'(spawn_pending), 1);
    repeat (10) tick(1'b1);
    chk("frz_pending", 32'(spawn_pending), 1);
    chk("frz_mask", 32'(active_mask), 1);
    lookup_x("frz_x", 1494, f0);

    // Gap rule: slot1 spawns on the first tick where slot0 x <= 1244 beforehand
    ticks_until_change(4'b0001, 60, n, pb);
    chk("gap_ticks", 32'(n), 43);
    chk("gap_pending_before", 32'(pb), 1);
    chk("gap_mask", 32'(active_mask), 32'b0011);
    chk("gap_pending_clr", 32'(spawn_pending), 0);
    lookup_x("gap_slot0_x", 1236, m_frame);
    lookup_x("gap_slot1_x", 1500, m_frame);

    press();
    ticks_until_change(4'b0011, 60, n, pb);
    chk("slot2_ticks", 32'(n), 44);
    chk("slot2_mask", 32'(active_mask), 32'b0111);
    press();
    ticks_until_change(4'b0111, 60, n, pb);
    chk("slot3_ticks", 32'(n), 44);
    chk("slot3_mask", 32'(active_mask), 32'b1111);

    // Full: slot0 (x=708) frees on tick 118, spawn lands on the next tick
    press();
    chk("full_pending", 32'(spawn_pending), 1);
    ticks_until_change(4'b1111, 200, n, pb);
    chk("full_free_ticks", 32'(n), 118);
    chk("full_free_mask", 32'(active_mask), 32'b1110);
    chk("full_still_pending", 32'(spawn_pending), 1);
    tick(1'b0);
    chk("full_respawn_mask", 32'(active_mask), 32'b1111);
    chk("full_respawn_pending", 32'(spawn_pending), 0);
    lookup_x("respawn_x", 1500, m_frame);

    // A fresh slot at 1500 frees on its 250th tick
    n = 0;
    while (active_mask[0] && n < 300) begin
      tick(1'b0);
      n++;
    end
    chk("free_ticks", 32'(n), 250);
    chk("free_all_mask", 32'(active_mask), 0);

    // Press landing on a tick clock is serviced at the following tick
    @(negedge clock);
    display_col = 12'd0;
    display_row = 11'd0;
    hit = 1'b0;
    spawn_key = 1'b1;
    @(negedge clock);
    idle();
    spawn_key = 1'b0;
    chk("tickpress_pending", 32'(spawn_pending), 1);
    chk("tickpress_mask", 32'(active_mask), 0);
    tick(1'b0);
    chk("tickpress_spawn", 32'(active_mask), 1);

    // Mid-frame reset drops obstacles and the pending request
    press();
    tick(1'b0);
    chk("pre_rst_pending", 32'(spawn_pending), 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midrst_mask", 32'(active_mask), 0);
    chk("midrst_pending", 32'(spawn_pending), 0);
    tick(1'b0);
    chk("midrst_no_spawn", 32'(active_mask), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
